// File: rtl/axi_aw_burst_splitter.sv
// Splits one DMA-style write request into AXI4 INCR bursts that are at most MAX_BURST beats long
// and never cross a 4 KiB boundary. It also reports each burst's beat count to the W-data side.
module axi_aw_burst_splitter #(
    parameter int AXI_AWID_WIDTH   = 1,
    parameter int AXI_AWADDR_WIDTH = 32,
    parameter int AXI_AWUSER_WIDTH = 1,
    parameter int AWID_VALUE       = 0,
    parameter int DATA_BYTES       = 8,
    parameter int MAX_BURST        = 16,
    parameter int LEN_WIDTH        = 24
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [AXI_AWADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]        req_len,
    output logic                        done,
    output logic                        busy,
    output logic [AXI_AWID_WIDTH-1:0]   awid,
    output logic [AXI_AWADDR_WIDTH-1:0] awaddr,
    output logic [7:0]                  awlen,
    output logic [2:0]                  awsize,
    output logic [1:0]                  awburst,
    output logic                        awlock,
    output logic [3:0]                  awcache,
    output logic [2:0]                  awprot,
    output logic [3:0]                  awqos,
    output logic [3:0]                  awregion,
    output logic [AXI_AWUSER_WIDTH-1:0] awuser,
    output logic                        awvalid,
    input  logic                        awready,
    output logic                        wb_valid,
    output logic [8:0]                  wb_beats,
    input  logic                        wb_ready
);
    localparam int AW        = AXI_AWADDR_WIDTH;
    localparam int SIZE_LOG2 = $clog2(DATA_BYTES);
    localparam int RW        = LEN_WIDTH + 1;
    localparam logic [AW-1:0] ALIGN_MASK = AW'(DATA_BYTES - 1);

    typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [RW-1:0] rem_q, rem_d;
    logic          aw_done_q, aw_done_d;
    logic          wb_done_q, wb_done_d;
    logic          req_ready_q, req_ready_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          awvalid_q, awvalid_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [7:0]    awlen_q, awlen_d;
    logic          wb_valid_q, wb_valid_d;
    logic [8:0]    wb_beats_q, wb_beats_d;

    logic [RW-1:0] req_beats;
    logic [12:0]   to_4k;
    logic [8:0]    rem_cap;
    logic [8:0]    burst_n;
    logic          aw_hs, wb_hs, aw_fin, wb_fin;

    // Beat count of the whole request, rounded up to full bus words.
    assign req_beats = (RW'(req_len) + RW'(DATA_BYTES - 1)) >> SIZE_LOG2;
    assign to_4k     = (13'h1000 - {1'b0, addr_q[11:0]}) >> SIZE_LOG2;
    assign rem_cap   = (rem_q > RW'(MAX_BURST)) ? 9'(MAX_BURST) : 9'(rem_q);
    assign burst_n   = (13'(rem_cap) > to_4k) ? 9'(to_4k) : rem_cap;

    assign aw_hs  = awvalid_q & awready;
    assign wb_hs  = wb_valid_q & wb_ready;
    assign aw_fin = aw_done_q | aw_hs;
    assign wb_fin = wb_done_q | wb_hs;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        aw_done_d   = aw_done_q;
        wb_done_d   = wb_done_q;
        req_ready_d = req_ready_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        awvalid_d   = awvalid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        wb_valid_d  = wb_valid_q;
        wb_beats_d  = wb_beats_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr_d = req_addr & ~ALIGN_MASK;
                    rem_d  = req_beats;
                    if (req_beats == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d      = 1'b1;
                        req_ready_d = 1'b0;
                        state_d     = CALC;
                    end
                end
            end
            CALC: begin
                awaddr_d   = addr_q;
                awlen_d    = 8'(burst_n - 9'd1);
                wb_beats_d = burst_n;
                awvalid_d  = 1'b1;
                wb_valid_d = 1'b1;
                aw_done_d  = 1'b0;
                wb_done_d  = 1'b0;
                state_d    = ISSUE;
            end
            ISSUE: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (wb_hs) wb_valid_d = 1'b0;
                aw_done_d = aw_fin;
                wb_done_d = wb_fin;
                // Advance only when both the AW and the W-side handshakes are complete.
                if (aw_fin && wb_fin) begin
                    aw_done_d = 1'b0;
                    wb_done_d = 1'b0;
                    addr_d    = addr_q + (AW'(wb_beats_q) << SIZE_LOG2);
                    rem_d     = rem_q - RW'(wb_beats_q);
                    if (rem_q == RW'(wb_beats_q)) begin
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        req_ready_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            aw_done_q   <= 1'b0;
            wb_done_q   <= 1'b0;
            req_ready_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            awvalid_q   <= 1'b0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_beats_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            aw_done_q   <= aw_done_d;
            wb_done_q   <= wb_done_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            awvalid_q   <= awvalid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            wb_valid_q  <= wb_valid_d;
            wb_beats_q  <= wb_beats_d;
        end
    end

    // A misaligned start address is a caller bug; the hardware simply clears the low bits.
    always_ff @(posedge aclk) begin
        if (aresetn && req_valid && req_ready_q)
            assert ((req_addr & ALIGN_MASK) == '0);
    end

    assign req_ready = req_ready_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = awaddr_q;
    assign awlen     = awlen_q;
    assign wb_valid  = wb_valid_q;
    assign wb_beats  = wb_beats_q;

    assign awid     = AXI_AWID_WIDTH'(AWID_VALUE);
    assign awsize   = 3'(SIZE_LOG2);
    assign awburst  = 2'b01;
    assign awlock   = 1'b0;
    assign awcache  = 4'b0011;
    assign awprot   = 3'b000;
    assign awqos    = 4'd0;
    assign awregion = 4'd0;
    assign awuser   = '0;
endmodule

// File: tb/tb_axi_aw_burst_splitter.sv
// Randomized scoreboard bench: a reference model queues the expected bursts for each request,
// and an independent monitor checks the AW and W-side handshakes against that queue.
module tb_axi_aw_burst_splitter;
    localparam int DB = 8;
    localparam int MB = 16;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [23:0] req_len = '0;
    logic        done, busy;
    logic [0:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic [3:0]  awqos;
    logic [3:0]  awregion;
    logic [0:0]  awuser;
    logic        awvalid;
    logic        awready = 1'b0;
    logic        wb_valid;
    logic [8:0]  wb_beats;
    logic        wb_ready = 1'b0;

    axi_aw_burst_splitter dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .done(done), .busy(busy),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
        .awregion(awregion), .awuser(awuser), .awvalid(awvalid), .awready(awready),
        .wb_valid(wb_valid), .wb_beats(wb_beats), .wb_ready(wb_ready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    burst_t aw_q[$];
    int     wb_q[$];
    int     checks = 0;
    int     fails = 0;
    int     cyc = 0;
    int     done_seen = 0;
    int     aw_pops = 0;
    int     rdy_mode = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: walk the request in beats, cutting at MAX_BURST and at each 4 KiB page.
    task automatic model_push(input logic [31:0] a, input int len);
        int          rem, n, to4k;
        logic [31:0] ad;
        burst_t      b;
        rem = (len + DB - 1) / DB;
        ad  = a;
        while (rem > 0) begin
            to4k = (4096 - int'(ad % 4096)) / DB;
            n = rem;
            if (n > MB) n = MB;
            if (n > to4k) n = to4k;
            b.addr = ad;
            b.len  = 8'(n - 1);
            aw_q.push_back(b);
            wb_q.push_back(n);
            ad  = ad + 32'(n * DB);
            rem = rem - n;
        end
    endtask

    // Ready generator: random in mode 0, fixed back-pressure (AW 5 cycles, W 3 cycles) in mode 1.
    initial begin
        int aw_cnt, wb_cnt;
        aw_cnt = 0;
        wb_cnt = 0;
        forever begin
            @(posedge aclk);
            #1;
            aw_cnt = awvalid ? aw_cnt + 1 : 0;
            wb_cnt = wb_valid ? wb_cnt + 1 : 0;
            if (rdy_mode == 0) begin
                awready = ($urandom_range(0, 99) < 60);
                wb_ready = ($urandom_range(0, 99) < 50);
            end else begin
                awready = (aw_cnt > 5);
                wb_ready = (wb_cnt > 3);
            end
        end
    end

    // Monitor: stability, ordering, latency and scoreboard compares.
    initial begin
        logic        p_awv, p_awr, p_wbv, p_wbr, aw_f, wb_f, trig_pend;
        logic [31:0] p_addr;
        logic [7:0]  p_len;
        logic [8:0]  p_beats;
        int          trig;
        burst_t      e;
        int          eb;
        p_awv = 0; p_awr = 0; p_wbv = 0; p_wbr = 0; aw_f = 0; wb_f = 0; trig_pend = 0;
        p_addr = '0; p_len = '0; p_beats = '0; trig = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                p_awv = 0; p_wbv = 0; aw_f = 0; wb_f = 0; trig_pend = 0;
                continue;
            end
            if (p_awv && !p_awr)
                check("aw_hold", awvalid && awaddr == p_addr && awlen == p_len,
                      {awvalid, awaddr, awlen}, {1'b1, p_addr, p_len});
            if (p_wbv && !p_wbr)
                check("wb_hold", wb_valid && wb_beats == p_beats, {wb_valid, wb_beats}, {1'b1, p_beats});
            if (awvalid && !p_awv) begin
                check("aw_latency", trig_pend && cyc == trig + 2 && wb_valid, cyc, trig + 2);
                trig_pend = 0;
            end
            if (req_valid && req_ready) begin
                trig = cyc;
                trig_pend = (req_len != 0);
            end
            if (awvalid && awready) begin
                aw_f = 1;
                aw_pops++;
                if (aw_q.size() == 0) check("aw_unexpected", 1'b0, awaddr, 0);
                else begin
                    e = aw_q.pop_front();
                    check("aw_burst", awaddr == e.addr && awlen == e.len, {awaddr, awlen}, {e.addr, e.len});
                end
            end
            if (wb_valid && wb_ready) begin
                wb_f = 1;
                if (wb_q.size() == 0) check("wb_unexpected", 1'b0, wb_beats, 0);
                else begin
                    eb = wb_q.pop_front();
                    check("wb_beats", wb_beats == 9'(eb), wb_beats, eb);
                end
            end
            if (aw_f && wb_f) begin
                aw_f = 0;
                wb_f = 0;
                trig = cyc;
                trig_pend = (aw_q.size() > 0);
            end
            if (done) begin
                check("done_after_last", aw_q.size() == 0 && wb_q.size() == 0 && !aw_f && !wb_f,
                      aw_q.size() + wb_q.size(), 0);
                done_seen++;
            end
            p_awv = awvalid; p_awr = awready; p_addr = awaddr; p_len = awlen;
            p_wbv = wb_valid; p_wbr = wb_ready; p_beats = wb_beats;
        end
    end

    task automatic accept_req(input logic [31:0] a, input int len);
        int t;
        model_push(a, len);
        @(posedge aclk);
        #1;
        req_addr = a;
        req_len = 24'(len);
        req_valid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!req_ready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        if (!req_ready) check("req_accept_timeout", 1'b0, 0, 1);
        @(posedge aclk);
        #1;
        req_valid = 1'b0;
        check("busy_after_accept", busy == (len != 0), busy, len != 0);
    endtask

    task automatic do_req(input logic [31:0] a, input int len);
        int t, start;
        start = done_seen;
        $display("req addr=0x%08h len=%0d", a, len);
        accept_req(a, len);
        t = 0;
        while (done_seen == start && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        check("done_seen", done_seen > start, done_seen - start, 1);
        check("idle_after_done", !busy && req_ready, {busy, req_ready}, 2'b01);
        repeat (3) @(negedge aclk);
        check("done_once", done_seen == start + 1, done_seen - start, 1);
    endtask

    initial begin
        int t;
        #12;
        check("rst_outputs", {req_ready, busy, done, awvalid, wb_valid} == 5'b0 &&
              awaddr == 0 && awlen == 0 && wb_beats == 0, {req_ready, busy, done, awvalid, wb_valid}, 0);
        check("rst_consts", awsize == 3'd3 && awburst == 2'b01 && awcache == 4'b0011 &&
              awid == 1'b0 && awlock == 0 && awprot == 0 && awqos == 0 && awregion == 0 && awuser == 0,
              {awsize, awburst, awcache}, {3'd3, 2'b01, 4'b0011});
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        do_req(32'h0000_0000, 20);
        do_req(32'h0000_0FF0, 64);
        do_req(32'h0000_0000, 4096);
        do_req(32'h0000_0100, 0);
        rdy_mode = 1;
        do_req(32'h0000_0FF0, 64);
        rdy_mode = 0;

        // Reset during the second burst of a 4 KiB transfer.
        $display("req addr=0x00000000 len=4096 (reset mid-burst)");
        accept_req(32'h0000_0000, 4096);
        t = 0;
        @(negedge aclk);
        while (!(aw_pops >= 1 && awvalid) && t < 200) begin
            @(negedge aclk);
            t++;
        end
        check("reach_burst2", awvalid, awvalid, 1);
        aw_pops = 0;
        #2;
        aresetn = 1'b0;
        #1;
        check("async_reset", {awvalid, wb_valid, busy, req_ready} == 4'b0 && awaddr == 0 && awlen == 0,
              {awvalid, wb_valid, busy, req_ready}, 0);
        aw_q.delete();
        wb_q.delete();
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        do_req(32'h0000_2000, 8);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] a;
            int          l;
            a = {17'h0, 12'($urandom_range(0, 4095)), 3'b000};
            if (i % 4 == 0) a = 32'h0000_1000 - 32'($urandom_range(1, 20) * DB);
            l = $urandom_range(0, 700);
            do_req(a, l);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
